// File: rtl/alu_uart_sequencer.sv
// alu_uart_sequencer
//   Byte-serial front end for the combinational ALU. Collects operand A, operand B and
//   the opcode as three UART bytes, holds them on registered ALU inputs, latches the
//   ALU result one clock later and sends it back through the UART transmitter.
//
// Parameters
//   NB_DATA         operand/result/UART byte width
//   NB_OP           ALU opcode width (low NB_OP bits of the opcode byte)
//   TIMEOUT_CYCLES  inter-byte timeout in clocks, 0 disables the timeout logic
//
// Optional feature (macro FLAGS_TX_EN)
//   When defined, a second byte {0.., carry, zero} is sent after the result byte.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_rx_data, i_rx_done      received byte and its one-cycle strobe
//   i_tx_done                 transmitter finished the current byte
//   o_tx_data, o_tx_start     byte to transmit and its one-cycle start pulse
//   o_alu_a, o_alu_b, o_alu_op  registered ALU operands and opcode
//   i_alu_result, i_alu_carry, i_alu_zero  ALU outputs
//   o_busy                    high whenever a frame is in progress
//   o_err                     one-cycle pulse on inter-byte timeout
module alu_uart_sequencer #(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned NB_OP          = 6,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic               i_rx_done,
  input  logic               i_tx_done,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_alu_carry,
  input  logic               i_alu_zero,
  output logic               o_busy,
  output logic               o_err
);

  typedef enum logic [2:0] {
    StWaitA,
    StWaitB,
    StWaitOp,
    StExec,
    StSendRes,
`ifdef FLAGS_TX_EN
    StWaitTx,
    StSendFlg,
    StWaitFlg
`else
    StWaitTx
`endif
  } state_e;

  state_e             state_q;
  logic [NB_DATA-1:0] alu_a_q;
  logic [NB_DATA-1:0] alu_b_q;
  logic [NB_OP-1:0]   alu_op_q;
  logic [NB_DATA-1:0] tx_data_q;
  logic               tx_start_q;
  logic               timeout_hit;

`ifdef FLAGS_TX_EN
  logic carry_q;
  logic zero_q;
`else
  logic unused_flags;
  assign unused_flags = i_alu_carry ^ i_alu_zero;
`endif

  // Timeout counter only exists when a timeout is configured. The hit is evaluated in
  // the cycle the count reaches its limit, so a byte arriving that cycle still wins.
  generate
    if (TIMEOUT_CYCLES > 0) begin : g_timeout
      localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
      logic [CntW-1:0] cnt_q;
      logic            counting;

      assign counting = (state_q == StWaitB) || (state_q == StWaitOp);

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          cnt_q <= '0;
        end else if (i_rx_done || !counting) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end

      assign timeout_hit = counting && !i_rx_done && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
    end else begin : g_no_timeout
      assign timeout_hit = 1'b0;
    end
  endgenerate

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= StWaitA;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      tx_data_q  <= '0;
      tx_start_q <= 1'b0;
`ifdef FLAGS_TX_EN
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
`endif
    end else begin
      tx_start_q <= 1'b0;
      unique case (state_q)
        StWaitA: begin
          if (i_rx_done) begin
            alu_a_q <= i_rx_data;
            state_q <= StWaitB;
          end
        end
        StWaitB: begin
          if (i_rx_done) begin
            alu_b_q <= i_rx_data;
            state_q <= StWaitOp;
          end else if (timeout_hit) begin
            state_q <= StWaitA;
          end
        end
        StWaitOp: begin
          if (i_rx_done) begin
            alu_op_q <= i_rx_data[NB_OP-1:0];
            state_q  <= StExec;
          end else if (timeout_hit) begin
            state_q <= StWaitA;
          end
        end
        StExec: begin
          // Operands have been stable for a full cycle; the ALU output is settled.
          tx_data_q  <= i_alu_result;
          tx_start_q <= 1'b1;
`ifdef FLAGS_TX_EN
          carry_q    <= i_alu_carry;
          zero_q     <= i_alu_zero;
`endif
          state_q    <= StSendRes;
        end
        StSendRes: begin
          state_q <= StWaitTx;
        end
        StWaitTx: begin
          if (i_tx_done) begin
`ifdef FLAGS_TX_EN
            tx_data_q  <= {{(NB_DATA - 2){1'b0}}, carry_q, zero_q};
            tx_start_q <= 1'b1;
            state_q    <= StSendFlg;
`else
            state_q    <= StWaitA;
`endif
          end
        end
`ifdef FLAGS_TX_EN
        StSendFlg: begin
          state_q <= StWaitFlg;
        end
        StWaitFlg: begin
          if (i_tx_done) begin
            state_q <= StWaitA;
          end
        end
`endif
        default: begin
          state_q <= StWaitA;
        end
      endcase
    end
  end

  assign o_alu_a    = alu_a_q;
  assign o_alu_b    = alu_b_q;
  assign o_alu_op   = alu_op_q;
  assign o_tx_data  = tx_data_q;
  assign o_tx_start = tx_start_q;
  assign o_busy     = (state_q != StWaitA);
  assign o_err      = timeout_hit;

endmodule

// File: tb/tb_alu_uart_sequencer.sv
module tb_alu_uart_sequencer;

  localparam int unsigned Tmo = 16;
`ifdef FLAGS_TX_EN
  localparam bit FlagsEn = 1'b1;
`else
  localparam bit FlagsEn = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic       tx_done = 1'b0;
  logic [7:0] tx_data;
  logic       tx_start;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [5:0] alu_op;
  logic [7:0] alu_r;
  logic       alu_c;
  logic       alu_z;
  logic       busy;
  logic       err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_uart_sequencer #(
    .NB_DATA       (8),
    .NB_OP         (6),
    .TIMEOUT_CYCLES(Tmo)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_rx_data   (rx_data),
    .i_rx_done   (rx_done),
    .i_tx_done   (tx_done),
    .o_tx_data   (tx_data),
    .o_tx_start  (tx_start),
    .o_alu_a     (alu_a),
    .o_alu_b     (alu_b),
    .o_alu_op    (alu_op),
    .i_alu_result(alu_r),
    .i_alu_carry (alu_c),
    .i_alu_zero  (alu_z),
    .o_busy      (busy),
    .o_err       (err)
  );

  // Reference ALU: returns {carry, zero, result}.
  function automatic logic [9:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [5:0] op);
    logic [8:0] w;
    logic [7:0] r;
    logic       c;
    c = 1'b0;
    r = 8'h00;
    case (op)
      6'h20: begin w = {1'b0, a} + {1'b0, b}; r = w[7:0]; c = w[8]; end
      6'h22: begin w = {1'b0, a} - {1'b0, b}; r = w[7:0]; c = w[8]; end
      6'h24: r = a & b;
      6'h25: r = a | b;
      6'h26: r = a ^ b;
      6'h27: r = ~(a | b);
      6'h02: r = a >> b[2:0];
      6'h03: r = $signed(a) >>> b[2:0];
      default: r = 8'h00;
    endcase
    return {c, (r == 8'h00), r};
  endfunction

  always_comb begin
    {alu_c, alu_z, alu_r} = alu_f(alu_a, alu_b, alu_op);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      if (errors < 30) $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: bytes collected in the current frame, a countdown to the next
  // transmit pulse, and whether a transmitted byte is awaiting tx_done.
  int         m_n = 0;
  int         m_cd = -1;
  bit         m_wait = 0;
  bit         m_flag_sent = 0;
  int         m_idle = 0;
  bit         m_start = 0;
  logic [7:0] m_data = 8'h00;
  logic [7:0] m_a = 8'h00;
  logic [7:0] m_b = 8'h00;
  logic [5:0] m_op = 6'h00;
  logic [7:0] m_res = 8'h00;
  logic [7:0] m_flg = 8'h00;

  always @(posedge clk or negedge rst_n) begin
    logic [9:0] f;
    if (!rst_n) begin
      m_n = 0; m_cd = -1; m_wait = 0; m_flag_sent = 0; m_idle = 0; m_start = 0;
      m_data = 8'h00; m_a = 8'h00; m_b = 8'h00; m_op = 6'h00;
    end else if (m_cd == 1) begin
      m_cd = 0; m_start = 1; m_data = m_res;
    end else if (m_cd == 0) begin
      m_cd = -1; m_start = 0; m_wait = 1;
    end else if (m_wait) begin
      if (tx_done) begin
        m_wait = 0;
        if (FlagsEn && !m_flag_sent) begin
          m_cd = 0; m_start = 1; m_data = m_flg; m_flag_sent = 1;
        end
      end
    end else if (rx_done) begin
      m_idle = 0;
      if (m_n == 0) begin
        m_a = rx_data; m_n = 1;
      end else if (m_n == 1) begin
        m_b = rx_data; m_n = 2;
      end else begin
        m_op = rx_data[5:0]; m_n = 0; m_cd = 1; m_flag_sent = 0;
        f = alu_f(m_a, m_b, m_op);
        m_res = f[7:0];
        m_flg = {6'b0, f[9], f[8]};
      end
    end else if (m_n > 0) begin
      if (m_idle == int'(Tmo) - 1) begin
        m_n = 0; m_idle = 0;
      end else begin
        m_idle++;
      end
    end
  end

  // Per-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    bit exp_err;
    exp_err = (m_cd < 0) && !m_wait && (m_n > 0) && (m_idle == int'(Tmo) - 1) && !rx_done
              && rst_n;
    chk("cyc_tx_start", 32'(tx_start), 32'(m_start));
    if (m_start) chk("cyc_tx_data", 32'(tx_data), 32'(m_data));
    chk("cyc_busy", 32'(busy), 32'((m_n != 0) || (m_cd >= 0) || m_wait));
    chk("cyc_err", 32'(err), 32'(exp_err));
    chk("cyc_alu_a", 32'(alu_a), 32'(m_a));
    chk("cyc_alu_b", 32'(alu_b), 32'(m_b));
    chk("cyc_alu_op", 32'(alu_op), 32'(m_op));
  end

  // Callers are positioned 2 time units after a rising edge.
  task automatic send_byte(input logic [7:0] d);
    rx_data = d;
    rx_done = 1'b1;
    @(posedge clk); #2;
    rx_done = 1'b0;
  endtask

  task automatic pulse_tx_done();
    tx_done = 1'b1;
    @(posedge clk); #2;
    tx_done = 1'b0;
  endtask

  task automatic run_frame(input string name, input logic [7:0] a, input logic [7:0] b,
                           input logic [7:0] op, input logic [7:0] exp_res,
                           input logic [7:0] exp_flg, input bit inject);
    send_byte(a);
    send_byte(b);
    send_byte(op);
    chk({name, "_no_start_exec"}, 32'(tx_start), 32'd0);
    @(posedge clk); #2;
    chk({name, "_start"}, 32'(tx_start), 32'd1);
    chk({name, "_res"}, 32'(tx_data), 32'(exp_res));
    @(posedge clk); #2;
    if (inject) begin
      send_byte(8'hAA);
      chk({name, "_a_kept"}, 32'(alu_a), 32'(a));
    end
    pulse_tx_done();
    if (FlagsEn) begin
      chk({name, "_flg_start"}, 32'(tx_start), 32'd1);
      chk({name, "_flg"}, 32'(tx_data), 32'(exp_flg));
      @(posedge clk); #2;
      pulse_tx_done();
    end
    chk({name, "_idle"}, 32'(busy), 32'd0);
  endtask

  logic [7:0] ops [8] = '{8'h20, 8'h22, 8'h24, 8'h25, 8'h26, 8'h27, 8'h02, 8'hE0};

  initial begin
    int hit;
    int quiet;
    rst_n = 1'b0;
    #3;
    chk("rst_tx_start", 32'(tx_start), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_alu", 32'({alu_a, alu_b, 2'b00, alu_op}), 32'd0);
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    run_frame("add", 8'h05, 8'h03, 8'h20, 8'h08, 8'h00, 1'b0);
    run_frame("sub", 8'h03, 8'h05, 8'h22, 8'hFE, 8'h02, 1'b0);
    run_frame("and", 8'hF0, 8'h0F, 8'h24, 8'h00, 8'h01, 1'b0);
    run_frame("undef_op", 8'h12, 8'h34, 8'h3F, 8'h00, 8'h01, 1'b0);

    // Inter-byte timeout after a lone first byte.
    send_byte(8'h11);
    hit = -1;
    for (int i = 1; i <= 20; i++) begin
      if (err && hit < 0) hit = i;
      if (i == 17) chk("tmo_busy_after", 32'(busy), 32'd0);
      @(posedge clk); #2;
    end
    chk("tmo_err_cycle", 32'(hit), 32'd16);
    run_frame("after_tmo", 8'h01, 8'h01, 8'h20, 8'h02, 8'h00, 1'b0);

    run_frame("drop_rx", 8'h07, 8'h02, 8'h20, 8'h09, 8'h00, 1'b1);
    run_frame("post_drop", 8'h09, 8'h03, 8'h26, 8'h0A, 8'h00, 1'b0);

    // Asynchronous reset while waiting for the opcode.
    send_byte(8'h12);
    send_byte(8'h34);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_alu_a", 32'(alu_a), 32'd0);
    chk("arst_alu_b", 32'(alu_b), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_tx", 32'({tx_start, tx_data}), 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(posedge clk); #2;

    // Randomized traffic; the per-cycle compare checks every cycle.
    quiet = 0;
    for (int i = 0; i < 4000; i++) begin
      if (quiet > 0) begin
        quiet--;
        rx_done = 1'b0;
      end else begin
        rx_done = ($urandom_range(0, 3) == 0);
        if ($urandom_range(0, 40) == 0) quiet = $urandom_range(10, 24);
      end
      rx_data = ($urandom_range(0, 2) == 0) ? ops[$urandom_range(0, 7)] : 8'($urandom);
      tx_done = ($urandom_range(0, 4) == 0);
      if (i == 2000) begin
        #1 rst_n = 1'b0;
        #4 rst_n = 1'b1;
      end
      @(posedge clk); #2;
    end
    rx_done = 1'b0;
    tx_done = 1'b0;
    repeat (4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
